// File: rtl/cnn_pkg.sv
// Shared CNN datapath types: pixel/window bundles, pooling size, buffer FSM states.
// Window lane order is top-left, top-right, bottom-left, bottom-right (lane 0 in the LSBs).
package cnn_pkg;

  localparam int POOL_K = 2;

  typedef logic signed [15:0] pixel_t;
  typedef pixel_t [3:0] window_t;

  localparam int WIN_TL = 0;
  localparam int WIN_TR = 1;
  localparam int WIN_BL = 2;
  localparam int WIN_BR = 3;

  typedef enum logic [1:0] {
    FILL,
    SERVE,
    DONE
  } fmap_state_t;

endpackage

// File: rtl/window_addr_gen.sv
// Row/column walker for non-overlapping 2x2 windows over an N x N map.
// Advances one window per accepted handshake and flags the final window.
module window_addr_gen
  import cnn_pkg::*;
#(
  parameter int N = 4,
  localparam int RW = (N > 2) ? $clog2(N) : 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clr,
  input  logic          adv,
  output logic [RW-1:0] row,
  output logic [RW-1:0] col,
  output logic          last
);

  logic [RW-1:0] r_row;
  logic [RW-1:0] r_col;
  logic          w_last_col;

  assign w_last_col = (r_col == RW'(N - POOL_K));
  assign last = w_last_col &&
                (r_row == RW'(N - POOL_K));
  assign row = r_row;
  assign col = r_col;

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      r_row <= '0;
      r_col <= '0;
    end else if (adv) begin
      if (w_last_col) begin
        r_col <= '0;
        r_row <= r_row + RW'(POOL_K);
      end else begin
        r_col <= r_col + RW'(POOL_K);
      end
    end
  end

endmodule

// File: rtl/fmap_window_buffer.sv
// Collects an N x N feature map in raster order, then serves it as 2x2 windows.
// Define FMAP_RELU_EN to clamp negative pixels to zero before storage.
module fmap_window_buffer
  import cnn_pkg::*;
#(
  parameter int N  = 4,
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_data,
  output logic          win_valid,
  input  logic          win_ready,
  output logic [4*DW-1:0] win_data,
  output logic          win_last,
  output logic          done
);

  localparam int AW = $clog2(N * N);
  localparam int RW = (N > 2) ? $clog2(N) : 1;

  fmap_state_t   r_state;
  fmap_state_t   w_next;
  logic [AW-1:0] r_wr_cnt;
  logic [DW-1:0] r_mem [N*N];

  logic          w_in_fire;
  logic          w_win_fire;
  logic          w_last;
  logic [RW-1:0] w_row;
  logic [RW-1:0] w_col;
  logic [DW-1:0] w_wdata;
  logic [AW-1:0] w_tl;
  logic [AW-1:0] w_tr;
  logic [AW-1:0] w_bl;
  logic [AW-1:0] w_br;

  assign w_in_fire  = in_valid && in_ready;
  assign w_win_fire = win_valid && win_ready;

`ifdef FMAP_RELU_EN
  assign w_wdata = in_data[DW-1] ? '0 : in_data;
`else
  assign w_wdata = in_data;
`endif

  always_ff @(posedge clk) begin
    if (reset) r_state <= FILL;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      FILL: begin
        if (w_in_fire && r_wr_cnt == AW'(N*N - 1))
          w_next = SERVE;
      end
      SERVE: begin
        if (w_win_fire && w_last)
          w_next = DONE;
      end
      DONE:    w_next = FILL;
      default: w_next = FILL;
    endcase
  end

  always_comb begin
    in_ready  = (r_state == FILL);
    win_valid = (r_state == SERVE);
    win_last  = (r_state == SERVE) && w_last;
    done      = (r_state == DONE);
  end

  always_ff @(posedge clk) begin
    if (reset || r_state == DONE)
      r_wr_cnt <= '0;
    else if (w_in_fire)
      r_wr_cnt <= r_wr_cnt + AW'(1);
  end

  // Pixel storage is intentionally never cleared; a new fill overwrites it.
  always_ff @(posedge clk) begin
    if (w_in_fire)
      r_mem[r_wr_cnt] <= w_wdata;
  end

  window_addr_gen #(.N(N)) u_addr (
    .clk   (clk),
    .reset (reset),
    .clr   (r_state == DONE),
    .adv   (w_win_fire),
    .row   (w_row),
    .col   (w_col),
    .last  (w_last)
  );

  assign w_tl = AW'(w_row) * AW'(N) + AW'(w_col);
  assign w_tr = w_tl + AW'(1);
  assign w_bl = w_tl + AW'(N);
  assign w_br = w_bl + AW'(1);

  assign win_data = {r_mem[w_br], r_mem[w_bl],
                     r_mem[w_tr], r_mem[w_tl]};

endmodule

// File: tb/tb_fmap_window_buffer.sv
// Directed bench for fmap_window_buffer (N=4, DW=16).
// Covers stalls, input gaps, mid-fill reset, ReLU build option and back-to-back maps.
module tb_fmap_window_buffer;

  localparam int N  = 4;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic          win_valid;
  logic          win_ready;
  logic [4*DW-1:0] win_data;
  logic          win_last;
  logic          done;

  fmap_window_buffer #(.N(N), .DW(DW)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .win_valid (win_valid),
    .win_ready (win_ready),
    .win_data  (win_data),
    .win_last  (win_last),
    .done      (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] tl;
    logic [15:0] tr;
    logic [15:0] bl;
    logic [15:0] br;
    logic        last;
  } vec_t;

  vec_t        tab [4];
  vec_t        exp_w [4];
  logic [15:0] pix [16];
  int          total = 0;
  int          bad = 0;

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%h required=%h",
               nm, act, req);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_map(input bit gap);
    for (int k = 0; k < N*N; k++) begin
      if (gap && (k % 2 == 1)) begin
        in_valid = 1'b0;
        in_data  = 16'hDEAD;
        step();
      end
      in_valid = 1'b1;
      in_data  = pix[k];
      chk("fill_ready", 64'(in_ready), 64'd1);
      chk("fill_noval", 64'(win_valid), 64'd0);
      chk("fill_nodone", 64'(done), 64'd0);
      step();
    end
    in_valid = 1'b0;
  endtask

  task automatic collect(input int stall_w,
                         input int stall_n,
                         input bit poke);
    logic [63:0] want;
    in_valid = poke;
    in_data  = 16'hBEEF;
    for (int w = 0; w < 4; w++) begin
      want = {exp_w[w].br, exp_w[w].bl,
              exp_w[w].tr, exp_w[w].tl};
      for (int s = 0; s < ((w == stall_w) ? stall_n : 0); s++) begin
        win_ready = 1'b0;
        chk("stall_valid", 64'(win_valid), 64'd1);
        chk("stall_data", win_data, want);
        chk("stall_last", 64'(win_last), 64'(exp_w[w].last));
        step();
      end
      win_ready = 1'b1;
      chk("win_valid", 64'(win_valid), 64'd1);
      chk("win_data", win_data, want);
      chk("win_last", 64'(win_last), 64'(exp_w[w].last));
      chk("serve_ready", 64'(in_ready), 64'd0);
      chk("serve_nodone", 64'(done), 64'd0);
      step();
    end
    win_ready = 1'b0;
    chk("done_pulse", 64'(done), 64'd1);
    chk("done_noval", 64'(win_valid), 64'd0);
    chk("done_ready", 64'(in_ready), 64'd0);
    step();
    in_valid = 1'b0;
    chk("done_clear", 64'(done), 64'd0);
    chk("refill_ready", 64'(in_ready), 64'd1);
  endtask

  task automatic model_exp();
    int r;
    int c;
    for (int w = 0; w < 4; w++) begin
      r = (w / 2) * 2;
      c = (w % 2) * 2;
      exp_w[w].tl   = pix[r*N + c];
      exp_w[w].tr   = pix[r*N + c + 1];
      exp_w[w].bl   = pix[(r+1)*N + c];
      exp_w[w].br   = pix[(r+1)*N + c + 1];
      exp_w[w].last = (w == 3);
    end
  endtask

  task automatic ramp_pix(input logic [15:0] base);
    for (int k = 0; k < N*N; k++)
      pix[k] = base | 16'(k << 8);
  endtask

  initial begin
    tab[0] = '{16'h0000, 16'h0100, 16'h0400, 16'h0500, 1'b0};
    tab[1] = '{16'h0200, 16'h0300, 16'h0600, 16'h0700, 1'b0};
    tab[2] = '{16'h0800, 16'h0900, 16'h0C00, 16'h0D00, 1'b0};
    tab[3] = '{16'h0A00, 16'h0B00, 16'h0E00, 16'h0F00, 1'b1};

    reset     = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    win_ready = 1'b0;
    step();
    step();
    reset = 1'b0;
    chk("rst_ready", 64'(in_ready), 64'd1);
    chk("rst_valid", 64'(win_valid), 64'd0);
    chk("rst_last", 64'(win_last), 64'd0);
    chk("rst_done", 64'(done), 64'd0);

    ramp_pix(16'h0000);
    for (int w = 0; w < 4; w++) exp_w[w] = tab[w];
    send_map(1'b0);
    collect(-1, 0, 1'b0);

    send_map(1'b0);
    collect(1, 3, 1'b0);

    send_map(1'b1);
    collect(-1, 0, 1'b1);

    for (int k = 0; k < 7; k++) begin
      in_valid = 1'b1;
      in_data  = 16'h7777;
      step();
    end
    in_valid = 1'b0;
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("mid_rst_ready", 64'(in_ready), 64'd1);
    chk("mid_rst_valid", 64'(win_valid), 64'd0);
    chk("mid_rst_done", 64'(done), 64'd0);
    for (int k = 0; k < N*N; k++) pix[k] = 16'h0100;
    model_exp();
    send_map(1'b0);
    collect(-1, 0, 1'b0);

    ramp_pix(16'h0000);
    pix[0] = 16'hFC00;
    for (int w = 0; w < 4; w++) exp_w[w] = tab[w];
`ifdef FMAP_RELU_EN
    exp_w[0].tl = 16'h0000;
`else
    exp_w[0].tl = 16'hFC00;
`endif
    send_map(1'b0);
    collect(-1, 0, 1'b0);

    ramp_pix(16'h0033);
    model_exp();
    send_map(1'b0);
    collect(2, 1, 1'b0);
    ramp_pix(16'h2000);
    model_exp();
    send_map(1'b0);
    collect(-1, 0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
